// File: rtl/mpu_matrix_streamer_if.sv
// Bundle of the capture request, matrix input and element stream of mpu_matrix_streamer.
// The streamer connects through the slave modport, the host/sink through master.
`timescale 1ns/1ps
interface mpu_matrix_streamer_if;
  logic         start;
  logic [199:0] matrix;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   out_row;
  logic [2:0]   out_col;
  logic         out_last;
  logic         busy;
  logic         done;

  modport slave (
    input  start, matrix, out_ready,
    output out_data, out_valid, out_row, out_col, out_last, busy, done
  );

  modport master (
    output start, matrix, out_ready,
    input  out_data, out_valid, out_row, out_col, out_last, busy, done
  );
endinterface

// File: rtl/mpu_matrix_streamer.sv
// Captures a flat 5x5 byte matrix on start and streams it element by element,
// row index fastest, over a valid/ready handshake; done pulses once at the end.
`timescale 1ns/1ps
module mpu_matrix_streamer (
  input  logic                        clock,
  input  logic                        reset,
  mpu_matrix_streamer_if.slave        bus,
  output logic [1:0]                  dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]   state;
  logic [199:0] shadow;
  logic [2:0]   row;
  logic [2:0]   col;
  logic         send;
  logic         xfer;
  logic         at_end;

  // Handshake: out_valid is a pure function of state (high in SEND), so
  // out_ready never reaches it combinationally; an element transfers on a
  // rising edge with out_valid=1 and out_ready=1, and the payload holds
  // still until that happens.
  assign send   = (state == ST_SEND);
  assign xfer   = send && bus.out_ready;
  assign at_end = (row == 3'd4) && (col == 3'd4);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      row   <= 3'd0;
      col   <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state <= ST_SEND;
            row   <= 3'd0;
            col   <= 3'd0;
          end
        end
        ST_SEND: begin
          if (bus.out_ready) begin
            if (at_end) begin
              state <= ST_DONE;
              row   <= 3'd0;
              col   <= 3'd0;
            end else if (row == 3'd4) begin
              row <= 3'd0;
              col <= col + 3'd1;
            end else begin
              row <= row + 3'd1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          row   <= 3'd0;
          col   <= 3'd0;
        end
      endcase
    end
  end

  // The shadow shifts down one byte per transfer, so the current element is
  // always in the low byte; it is never visible outside SEND.
  always_ff @(posedge clock) begin
    if ((state == ST_IDLE) && bus.start) begin
      shadow <= bus.matrix;
    end else if (xfer) begin
      shadow <= {8'h00, shadow[199:8]};
    end
  end

  assign bus.out_valid = send;
  assign bus.out_data  = send ? shadow[7:0] : 8'h00;
  assign bus.out_row   = send ? row : 3'd0;
  assign bus.out_col   = send ? col : 3'd0;
  assign bus.out_last  = send && at_end;
  assign bus.busy      = (state == ST_SEND) || (state == ST_DONE);
  assign bus.done      = (state == ST_DONE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_mpu_matrix_streamer.sv
// Self-checking bench for mpu_matrix_streamer: table of stream scenarios plus
// hand-written reset-abort and back-to-back sequences.
`timescale 1ns/1ps
module tb_mpu_matrix_streamer;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;

  always #5 clock = ~clock;

  mpu_matrix_streamer_if bus();

  mpu_matrix_streamer dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // entry = {last, col, row, data}
  logic [14:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    int pat;         // 0: k+1, 1: 00/FF alternating, 2: random
    int rmode;       // 0: ready=1, 1: toggle 1,0.., 2: 0 for 10 then 1, 3: random
    int flags;       // bit0: overwrite matrix + start mid-stream, bit1: hold start
    int exp_cycles;  // SEND cycles expected, -1 = not checked
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [14:0] obs();
    return {bus.out_last, bus.out_col, bus.out_row, bus.out_data};
  endfunction

  function automatic logic [199:0] make_matrix(input int pat);
    logic [199:0] m;
    m = '0;
    for (int k = 0; k < 25; k++) begin
      case (pat)
        0:       m[8*k +: 8] = 8'(k + 1);
        1:       m[8*k +: 8] = (k % 2 == 1) ? 8'hFF : 8'h00;
        default: m[8*k +: 8] = 8'($urandom_range(0, 255));
      endcase
    end
    return m;
  endfunction

  task automatic push_expected(input logic [199:0] m);
    for (int k = 0; k < 25; k++)
      exp_q.push_back({(k == 24), 3'(k / 5), 3'(k % 5), m[8*k +: 8]});
  endtask

  // ---------------- driver ----------------
  task automatic run_stream(input int pat, input int rmode, input int flags, input int exp_cycles);
    logic [199:0] m;
    logic [14:0]  prev;
    logic [14:0]  exp_e;
    logic         stalled;
    logic         r;
    int           c;
    m = make_matrix(pat);
    @(negedge clock);
    bus.matrix = m;
    bus.start  = 1'b1;
    push_expected(m);
    @(negedge clock);
    if ((flags & 2) == 0) bus.start = 1'b0;
    c = 0;
    stalled = 1'b0;
    prev = '0;
    while (exp_q.size() > 0 && c < 200) begin
      case (rmode)
        0:       r = 1'b1;
        1:       r = (c % 2 == 0);
        2:       r = (c >= 10);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = r;
      if ((flags & 1) != 0 && c == 5) begin
        bus.matrix = '1;
        bus.start  = 1'b1;
      end
      if ((flags & 1) != 0 && c == 6) bus.start = 1'b0;
      check("out_valid_in_send", 32'(bus.out_valid), 32'd1);
      check("busy_in_send", 32'(bus.busy), 32'd1);
      check("done_in_send", 32'(bus.done), 32'd0);
      if (stalled) check("stall_stable", 32'(obs()), 32'(prev));
      if (r) begin
        exp_e = exp_q.pop_front();
        check("element", 32'(obs()), 32'(exp_e));
      end
      stalled = !r;
      prev = obs();
      c++;
      @(negedge clock);
    end
    if (exp_q.size() > 0) begin
      check("stream_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    if (exp_cycles >= 0) check("stream_cycles", 32'(c), 32'(exp_cycles));
    check("done_valid", 32'(bus.out_valid), 32'd0);
    check("done_pulse", 32'(bus.done), 32'd1);
    check("done_busy", 32'(bus.busy), 32'd1);
    check("done_outputs_zero", 32'(obs()), 32'd0);
    @(negedge clock);
    check("idle_done", 32'(bus.done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_valid", 32'(bus.out_valid), 32'd0);
    check("idle_outputs_zero", 32'(obs()), 32'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0] = '{pat: 0, rmode: 0, flags: 0, exp_cycles: 25};
    vecs[1] = '{pat: 0, rmode: 1, flags: 0, exp_cycles: 49};
    vecs[2] = '{pat: 0, rmode: 0, flags: 1, exp_cycles: 25};
    vecs[3] = '{pat: 1, rmode: 2, flags: 0, exp_cycles: 35};
    vecs[4] = '{pat: 2, rmode: 3, flags: 0, exp_cycles: -1};

    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.matrix    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_outputs", 32'(obs()), 32'd0);
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    bus.matrix = make_matrix(0);
    repeat (3) begin
      @(negedge clock);
      check("idle_no_start", 32'(bus.out_valid), 32'd0);
    end

    for (int i = 0; i < 5; i++)
      run_stream(vecs[i].pat, vecs[i].rmode, vecs[i].flags, vecs[i].exp_cycles);

    // Reset asserted while element k=12 is presented.
    @(negedge clock);
    bus.matrix    = make_matrix(0);
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (12) @(negedge clock);
    check("pre_abort_element", 32'(obs()), 32'({1'b0, 3'd2, 3'd2, 8'd13}));
    #2 reset = 1'b1;
    #1;
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_outputs", 32'(obs()), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      check("post_abort_valid", 32'(bus.out_valid), 32'd0);
      check("post_abort_done", 32'(bus.done), 32'd0);
    end
    run_stream(0, 0, 0, 25);

    // start held high: recapture on the edge right after the idle cycle.
    run_stream(0, 0, 2, 25);
    @(negedge clock);
    check("b2b_recapture_valid", 32'(bus.out_valid), 32'd1);
    check("b2b_first_element", 32'(obs()), 32'({1'b0, 3'd0, 3'd0, 8'd1}));
    bus.start = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("final_idle", 32'(bus.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mpu_matrix_streamer.md
MPU_MATRIX_STREAMER -- requirements
Module: mpu_matrix_streamer

Interface
REQ-001 The block SHALL have no parameters; element width is fixed at 8 bits and matrix size at 5x5 (25 elements, 200-bit flat bus).
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to capture `matrix` and begin streaming; sampled only in IDLE.
REQ-005 matrix  input  200  flat 5x5 matrix; element (i,j) occupies bits [8*(i+5*j)+7 : 8*(i+5*j)].
REQ-006 out_data  output  8  current element value.
REQ-007 out_valid  output  1  out_data/out_row/out_col/out_last are valid.
REQ-008 out_ready  input  1  downstream accepts the element this cycle.
REQ-009 out_row  output  3  index i (0..4) of the current element.
REQ-010 out_col  output  3  index j (0..4) of the current element.
REQ-011 out_last  output  1  high with out_valid on element index 24 only.
REQ-012 busy  output  1  high in SEND and DONE states.
REQ-013 done  output  1  single-cycle pulse after the final element transfers.

Function
REQ-014 The FSM SHALL have states IDLE, SEND, DONE; encoding is free.
REQ-015 In IDLE with start=1 at edge T, the block SHALL copy `matrix` into an internal 200-bit shadow register, clear element index k to 0 and enter SEND at T+1.
REQ-016 Changes on `matrix` after the capture edge SHALL NOT affect streamed data.
REQ-017 start SHALL be ignored in SEND and DONE (no re-capture, no restart).
REQ-018 In SEND, out_valid SHALL be 1 and out_data SHALL equal shadow[8k+7:8k], with out_row=k mod 5, out_col=k/5.
REQ-019 A transfer occurs on an edge where out_valid=1 and out_ready=1; only then SHALL k increment.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last SHALL stay stable.
REQ-021 Elements SHALL be emitted in ascending k order 0..24, i.e. (0,0),(1,0)..(4,0),(0,1)..(4,4).
REQ-022 On the transfer of k=24, the FSM SHALL enter DONE; out_valid SHALL be 0 from that next cycle.
REQ-023 In DONE, done SHALL be 1 for exactly one cycle; the FSM SHALL then return to IDLE unconditionally.
REQ-024 When out_valid=0, out_data, out_row, out_col and out_last SHALL be driven 0.
REQ-025 Timing: first out_valid in the cycle after start; with out_ready held 1, 25 transfers occur on 25 consecutive edges, done is high in the 26th cycle after start-capture, and the next start is accepted in IDLE at the 27th cycle.
REQ-026 out_ready SHALL have no combinational path to out_valid; out_valid depends only on state.

Reset
REQ-027 On reset=1 (any cycle, asynchronous), the FSM SHALL go to IDLE, k to 0, and out_valid, out_last, busy, done, out_data, out_row, out_col SHALL all be 0.
REQ-028 Reset asserted mid-stream SHALL abort the transfer with no done pulse; after release the block waits for a new start.
REQ-029 The shadow register need not be reset; its content SHALL never be visible while out_valid=0.

Verification
REQ-030 Capture A[k]=k+1, start 1 cycle, out_ready=1 -> out_data 1..25 on consecutive cycles, (row,col) (0,0)..(4,4), out_last only with 25, done pulse next cycle.
REQ-031 Same matrix, out_ready toggling 1,0,1,0 -> 25 transfers total, outputs stable during every stall, no element skipped or repeated.
REQ-032 Overwrite `matrix` with all 8'hFF and pulse start mid-stream -> stream still outputs original values 1..25; no restart.
REQ-033 Assert reset at transfer k=12 -> all outputs 0 immediately, no done; new start then streams from k=0.
REQ-034 Matrix elements 8'h00 and 8'hFF alternating, out_ready=0 for 10 cycles then 1 -> first element held 10 cycles, then full ordered stream; busy high from SEND entry through done cycle.
REQ-035 Back-to-back: start held high continuously -> second capture occurs in IDLE exactly after done, giving 27-cycle period.
